// File: rtl/control_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states, opcodes,
// PC source codes and the opcode class enum.
package control_pkg;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StResetPc = 3'd1,
    StFetch   = 3'd2,
    StDecode  = 3'd3,
    StExecute = 3'd4,
    StUpdate  = 3'd5,
    StHalt    = 3'd6,
    StFault   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RESET  = 2'b11;

  typedef enum logic [3:0] {
    ClsNone,
    ClsLui,
    ClsAuipc,
    ClsJal,
    ClsJalr,
    ClsBranch,
    ClsLoad,
    ClsStore,
    ClsOpImm,
    ClsOp,
    ClsFence,
    ClsSystem
  } op_class_e;

endpackage

// File: rtl/control_op_classify.sv
// Combinational opcode classifier: maps IR[6:0] to legality, class and whether
// the instruction writes rd.
module control_op_classify
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output op_class_e  op_class,
  output logic       writes_rd
);

  always_comb begin
    legal     = 1'b1;
    op_class  = ClsNone;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI:    begin op_class = ClsLui;    writes_rd = 1'b1; end
      OPC_AUIPC:  begin op_class = ClsAuipc;  writes_rd = 1'b1; end
      OPC_JAL:    begin op_class = ClsJal;    writes_rd = 1'b1; end
      OPC_JALR:   begin op_class = ClsJalr;   writes_rd = 1'b1; end
      OPC_BRANCH: op_class = ClsBranch;
      OPC_LOAD:   begin op_class = ClsLoad;   writes_rd = 1'b1; end
      OPC_STORE:  op_class = ClsStore;
      OPC_OP_IMM: begin op_class = ClsOpImm;  writes_rd = 1'b1; end
      OPC_OP:     begin op_class = ClsOp;     writes_rd = 1'b1; end
      OPC_FENCE:  op_class = ClsFence;
      OPC_SYSTEM: op_class = ClsSystem;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the RV32I datapath: fetch handshake, decode, execute
// timing and PC/register-file update control.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic       control_unit_clock_in,
  input  logic       control_unit_reset_in,
  output logic       control_unit_ins_mem_req_out,
  input  logic       control_unit_ins_mem_ack_in,
  input  logic [6:0] control_unit_opcode_in,
  input  logic       control_unit_branch_taken_in,
  input  logic       control_unit_halt_in,
  output logic       control_unit_ir_set_out,
  output logic       control_unit_pc_set_out,
  output logic [1:0] control_unit_pc_src_out,
  output logic       control_unit_reg_write_out,
  output logic       control_unit_fault_out,
  output logic [2:0] control_unit_state_out
);

  localparam int unsigned WaitMax = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT : 1;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);
  localparam int unsigned ExecMax = (EXEC_CYCLES > LOAD_CYCLES) ? EXEC_CYCLES : LOAD_CYCLES;
  localparam int unsigned ExecW   = $clog2(ExecMax + 1);

  state_e          state_q;
  op_class_e       cls_q;
  logic            writes_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic [ExecW-1:0] exec_cnt_q;

  logic      dec_legal;
  op_class_e dec_class;
  logic      dec_writes;

  control_op_classify u_classify (
    .opcode    (control_unit_opcode_in),
    .legal     (dec_legal),
    .op_class  (dec_class),
    .writes_rd (dec_writes)
  );

  always_ff @(posedge control_unit_clock_in or posedge control_unit_reset_in) begin
    if (control_unit_reset_in) begin
      state_q    <= StInit;
      cls_q      <= ClsNone;
      writes_q   <= 1'b0;
      wait_cnt_q <= '0;
      exec_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StInit:    state_q <= StResetPc;
        StResetPc: state_q <= StFetch;
        StFetch: begin
          // An ack in the expiry cycle still completes the fetch.
          if (control_unit_ins_mem_ack_in) begin
            state_q    <= StDecode;
            wait_cnt_q <= '0;
          end else if (MEM_TIMEOUT != 0 && wait_cnt_q == WaitW'(MEM_TIMEOUT - 1)) begin
            state_q    <= StFault;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q != WaitW'(WaitMax)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StDecode: begin
          cls_q      <= dec_class;
          writes_q   <= dec_writes;
          exec_cnt_q <= (dec_class == ClsLoad) ? ExecW'(LOAD_CYCLES) : ExecW'(EXEC_CYCLES);
          if (!dec_legal)                  state_q <= StFault;
          else if (dec_class == ClsSystem) state_q <= StHalt;
          else                             state_q <= StExecute;
        end
        StExecute: begin
          if (exec_cnt_q <= ExecW'(1)) begin
            state_q    <= StUpdate;
            exec_cnt_q <= '0;
          end else begin
            exec_cnt_q <= exec_cnt_q - 1'b1;
          end
        end
        StUpdate: state_q <= control_unit_halt_in ? StHalt : StFetch;
        StHalt:   if (!control_unit_halt_in) state_q <= StFetch;
        StFault:  state_q <= StFault;
        default:  state_q <= StFault;
      endcase
    end
  end

  always_comb begin
    control_unit_ins_mem_req_out = 1'b0;
    control_unit_ir_set_out      = 1'b0;
    control_unit_pc_set_out      = 1'b0;
    control_unit_pc_src_out      = PC_SRC_PC4;
    control_unit_reg_write_out   = 1'b0;
    control_unit_fault_out       = 1'b0;
    control_unit_state_out       = state_q;
    unique case (state_q)
      StResetPc: begin
        control_unit_pc_set_out = 1'b1;
        control_unit_pc_src_out = PC_SRC_RESET;
      end
      StFetch: begin
        control_unit_ins_mem_req_out = 1'b1;
        control_unit_ir_set_out      = control_unit_ins_mem_ack_in;
      end
      StUpdate: begin
        control_unit_pc_set_out    = 1'b1;
        control_unit_reg_write_out = writes_q;
        if (cls_q == ClsJal || cls_q == ClsJalr) begin
          control_unit_pc_src_out = PC_SRC_JUMP;
        end else if (cls_q == ClsBranch && control_unit_branch_taken_in) begin
          control_unit_pc_src_out = PC_SRC_BRANCH;
        end
      end
      StFault: control_unit_fault_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class, timeout,
// illegal opcode, halt and reset paths cycle by cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       taken = 1'b0;
  logic       halt = 1'b0;
  logic       req, ir_set, pc_set, reg_write, fault;
  logic [1:0] pc_src;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .control_unit_clock_in        (clk),
    .control_unit_reset_in        (rst),
    .control_unit_ins_mem_req_out (req),
    .control_unit_ins_mem_ack_in  (ack),
    .control_unit_opcode_in       (opcode),
    .control_unit_branch_taken_in (taken),
    .control_unit_halt_in         (halt),
    .control_unit_ir_set_out      (ir_set),
    .control_unit_pc_set_out      (pc_set),
    .control_unit_pc_src_out      (pc_src),
    .control_unit_reg_write_out   (reg_write),
    .control_unit_fault_out       (fault),
    .control_unit_state_out       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (req ir pc src rw flt st)", tag, got, exp);
    end
  endtask

  // Settle, then compare the full output bundle against the expected fields.
  task automatic expect_out(input string tag, input bit r, input bit i, input bit p,
                            input logic [1:0] s, input bit w, input bit f,
                            input logic [2:0] st);
    #1;
    check(tag, {req, ir_set, pc_set, pc_src, reg_write, fault, state},
          {r, i, p, s, w, f, st});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic release_and_boot(input string tag);
    rst = 1'b0;
    expect_out({tag, "_init"}, 0, 0, 0, 2'b00, 0, 0, 3'd0);
    tick();
    expect_out({tag, "_resetpc"}, 0, 0, 1, 2'b11, 0, 0, 3'd1);
    tick();
    expect_out({tag, "_fetch"}, 1, 0, 0, 2'b00, 0, 0, 3'd2);
  endtask

  // Entered in FETCH; leaves after DECODE's clock edge.
  task automatic fetch_decode(input string tag, input logic [6:0] opc, input int waits);
    for (int k = 0; k < waits; k++) begin
      expect_out({tag, "_wait"}, 1, 0, 0, 2'b00, 0, 0, 3'd2);
      tick();
    end
    ack = 1'b1;
    opcode = opc;
    expect_out({tag, "_ack"}, 1, 1, 0, 2'b00, 0, 0, 3'd2);
    tick();
    ack = 1'b0;
    expect_out({tag, "_decode"}, 0, 0, 0, 2'b00, 0, 0, 3'd3);
    tick();
  endtask

  task automatic run_insn(input string tag, input logic [6:0] opc, input int waits,
                          input int ncyc, input bit tk, input logic [1:0] src, input bit rw);
    fetch_decode(tag, opc, waits);
    for (int k = 0; k < ncyc; k++) begin
      expect_out({tag, "_exec"}, 0, 0, 0, 2'b00, 0, 0, 3'd4);
      tick();
    end
    taken = tk;
    expect_out({tag, "_update"}, 0, 0, 1, src, rw, 0, 3'd5);
    tick();
    taken = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("reset_hold", 0, 0, 0, 2'b00, 0, 0, 3'd0);
    end
    release_and_boot("boot");

    run_insn("opimm", 7'b0010011, 2, 1, 0, 2'b00, 1);
    expect_out("opimm_next", 1, 0, 0, 2'b00, 0, 0, 3'd2);
    run_insn("br_t", 7'b1100011, 0, 1, 1, 2'b01, 0);
    expect_out("br_t_next", 1, 0, 0, 2'b00, 0, 0, 3'd2);
    run_insn("br_nt", 7'b1100011, 0, 1, 0, 2'b00, 0);
    expect_out("br_nt_next", 1, 0, 0, 2'b00, 0, 0, 3'd2);
    run_insn("load", 7'b0000011, 1, 2, 0, 2'b00, 1);
    expect_out("load_next", 1, 0, 0, 2'b00, 0, 0, 3'd2);
    run_insn("jal", 7'b1101111, 0, 1, 1, 2'b10, 1);
    expect_out("jal_next", 1, 0, 0, 2'b00, 0, 0, 3'd2);
    run_insn("store", 7'b0100011, 0, 1, 1, 2'b00, 0);
    expect_out("store_next", 1, 0, 0, 2'b00, 0, 0, 3'd2);

    // Ack arriving in the 8th FETCH cycle beats the timeout.
    run_insn("ack8", 7'b0110011, 7, 1, 0, 2'b00, 1);
    expect_out("ack8_next", 1, 0, 0, 2'b00, 0, 0, 3'd2);

    halt = 1'b1;
    run_insn("halt", 7'b0110111, 0, 1, 0, 2'b00, 1);
    expect_out("halt_enter", 0, 0, 0, 2'b00, 0, 0, 3'd6);
    tick();
    halt = 1'b0;
    expect_out("halt_stay", 0, 0, 0, 2'b00, 0, 0, 3'd6);
    tick();
    expect_out("halt_exit", 1, 0, 0, 2'b00, 0, 0, 3'd2);

    fetch_decode("illegal", 7'b1111111, 0);
    expect_out("illegal_fault", 0, 0, 0, 2'b00, 0, 1, 3'd7);
    ack = 1'b1;
    tick();
    expect_out("illegal_sticky", 0, 0, 0, 2'b00, 0, 1, 3'd7);
    ack = 1'b0;
    rst = 1'b1;
    expect_out("illegal_rst", 0, 0, 0, 2'b00, 0, 0, 3'd0);
    tick();
    release_and_boot("reboot1");

    for (int k = 0; k < 8; k++) begin
      expect_out("timeout_wait", 1, 0, 0, 2'b00, 0, 0, 3'd2);
      tick();
    end
    expect_out("timeout_fault", 0, 0, 0, 2'b00, 0, 1, 3'd7);
    tick();
    tick();
    expect_out("timeout_sticky", 0, 0, 0, 2'b00, 0, 1, 3'd7);
    rst = 1'b1;
    expect_out("timeout_rst", 0, 0, 0, 2'b00, 0, 0, 3'd0);
    tick();
    release_and_boot("reboot2");

    fetch_decode("midexec", 7'b0000011, 0);
    expect_out("midexec_exec", 0, 0, 0, 2'b00, 0, 0, 3'd4);
    rst = 1'b1;
    expect_out("midexec_rst", 0, 0, 0, 2'b00, 0, 0, 3'd0);
    tick();
    release_and_boot("reboot3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
